// File: rtl/chess_clock_pkg.sv
// Shared types and constants for the chess clock game sequencer.
package chess_clock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN_A = 3'd1,
    ST_RUN_B = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } ctrl_state_t;

  localparam logic PLAYER_A = 1'b0;
  localparam logic PLAYER_B = 1'b1;

  localparam logic [1:0] STOP_ALL   = 2'b11;
  localparam logic [1:0] STOP_RUN_A = 2'b10;
  localparam logic [1:0] STOP_RUN_B = 2'b01;

  function automatic logic [1:0] stop_for(input ctrl_state_t s);
    logic [1:0] r;
    case (s)
      ST_RUN_A: r = STOP_RUN_A;
      ST_RUN_B: r = STOP_RUN_B;
      default:  r = STOP_ALL;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/counter_dec_2w.sv
// Two-digit BCD up/down counter; synchronous reset loads i_count.
module counter_dec_2w (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_plus,
  input  logic            i_minus,
  input  logic [1:0][3:0] i_count,
  output logic [1:0][3:0] o_count
);

  logic [1:0][3:0] count_q;
  logic [1:0][3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_plus && !i_minus) begin
      if (count_q[0] == 4'd9) begin
        count_d[0] = 4'd0;
        count_d[1] = (count_q[1] == 4'd9) ? 4'd0 : count_q[1] + 4'd1;
      end else begin
        count_d[0] = count_q[0] + 4'd1;
      end
    end else if (i_minus && !i_plus) begin
      if (count_q[0] == 4'd0) begin
        count_d[0] = 4'd9;
        count_d[1] = (count_q[1] == 4'd0) ? 4'd9 : count_q[1] - 4'd1;
      end else begin
        count_d[0] = count_q[0] - 4'd1;
      end
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) count_q <= i_count;
    else       count_q <= count_d;
  end

  assign o_count = count_q;

endmodule

// File: rtl/chess_clock_ctrl.sv
// Two-player chess clock game sequencer: turn handling, pause, flag fall,
// reload pulses and a saturating BCD move counter.
module chess_clock_ctrl
  import chess_clock_pkg::*;
#(
  parameter int unsigned p_first    = 0,
  parameter int unsigned p_move_max = 99
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_pause,
  input  logic [1:0]      i_turn,
  input  logic [1:0]      i_zero,
  output logic [1:0]      o_stop,
  output logic [1:0]      o_win,
  output logic            o_reload,
  output logic [2:0]      o_state,
  output logic [1:0][3:0] o_moves
);

  localparam logic        FIRST      = (p_first != 0) ? PLAYER_B : PLAYER_A;
  localparam ctrl_state_t RUN_FIRST  = (p_first != 0) ? ST_RUN_B : ST_RUN_A;
  localparam logic [3:0]  MAX_TENS   = 4'(p_move_max / 10);
  localparam logic [3:0]  MAX_UNITS  = 4'(p_move_max % 10);

  ctrl_state_t     state_q, state_d;
  logic            side_q, side_d;
  logic [1:0]      win_q, win_d;
  logic [1:0]      stop_q, stop_d;
  logic            reload_q, reload_d;
  logic            boot_q;
  logic            on_move_s;
  logic            abort_s;
  logic            move_done_s;
  logic            count_plus_s;
  logic            count_clr_s;
  logic [1:0][3:0] moves_s;

  assign on_move_s = (state_q == ST_RUN_B) ? PLAYER_B : PLAYER_A;

  always_comb begin
    state_d     = state_q;
    side_d      = side_q;
    win_d       = win_q;
    abort_s     = 1'b0;
    move_done_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) state_d = RUN_FIRST;
        else         state_d = state_q;
      end
      ST_RUN_A, ST_RUN_B: begin
        // A flag on the side to move also covers the both-zero case: the idle side wins.
        if (i_start) begin
          state_d = ST_IDLE;
          abort_s = 1'b1;
        end else if (i_zero[on_move_s]) begin
          state_d = ST_OVER;
          win_d   = (on_move_s == PLAYER_A) ? 2'b10 : 2'b01;
        end else if (i_pause) begin
          state_d = ST_PAUSE;
          side_d  = on_move_s;
        end else if (i_turn[on_move_s]) begin
          state_d     = (on_move_s == PLAYER_A) ? ST_RUN_B : ST_RUN_A;
          move_done_s = (on_move_s != FIRST);
        end else begin
          state_d = state_q;
        end
      end
      ST_PAUSE: begin
        if (i_start) begin
          state_d = ST_IDLE;
          abort_s = 1'b1;
        end else if (i_pause) begin
          state_d = (side_q == PLAYER_B) ? ST_RUN_B : ST_RUN_A;
        end else begin
          state_d = state_q;
        end
      end
      ST_OVER: begin
        if (i_start) begin
          state_d = ST_IDLE;
          abort_s = 1'b1;
          win_d   = 2'b00;
        end else begin
          win_d = win_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    reload_d = boot_q | abort_s;
    stop_d   = stop_for(state_d);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      side_q   <= PLAYER_A;
      win_q    <= 2'b00;
      stop_q   <= STOP_ALL;
      reload_q <= 1'b0;
      boot_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      side_q   <= side_d;
      win_q    <= win_d;
      stop_q   <= stop_d;
      reload_q <= reload_d;
      boot_q   <= 1'b0;
    end
  end

  assign count_plus_s = move_done_s && !((moves_s[1] == MAX_TENS) && (moves_s[0] == MAX_UNITS));
  assign count_clr_s  = i_rst | abort_s;

  counter_dec_2w u_moves (
    .i_clk   (i_clk),
    .i_rst   (count_clr_s),
    .i_plus  (count_plus_s),
    .i_minus (1'b0),
    .i_count ({4'd0, 4'd0}),
    .o_count (moves_s)
  );

  assign o_stop   = stop_q;
  assign o_win    = win_q;
  assign o_reload = reload_q;
  assign o_state  = state_q;
  assign o_moves  = moves_s;

endmodule

// File: tb/tb_chess_clock_ctrl.sv
// Directed plus randomized bench for chess_clock_ctrl against a game-level reference model.
module tb_chess_clock_ctrl;

  localparam int P_FIRST = 0;
  localparam int P_MAX   = 99;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            pause;
  logic [1:0]      turn;
  logic [1:0]      zero;
  logic [1:0]      o_stop;
  logic [1:0]      o_win;
  logic            o_reload;
  logic [2:0]      o_state;
  logic [1:0][3:0] o_moves;

  int checks = 0;
  int errors = 0;

  // Reference model: game phase, side on move, plain integer move count.
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_PAUSE = 2, PH_OVER = 3;
  int         m_phase;
  int         m_side;
  int         m_moves;
  logic [1:0] m_win;
  logic       m_reload;
  logic       m_boot;

  chess_clock_ctrl #(.p_first(P_FIRST), .p_move_max(P_MAX)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_pause  (pause),
    .i_turn   (turn),
    .i_zero   (zero),
    .o_stop   (o_stop),
    .o_win    (o_win),
    .o_reload (o_reload),
    .o_state  (o_state),
    .o_moves  (o_moves)
  );

  always #5 clk = ~clk;

  task automatic model(input logic r, s, p, input logic [1:0] t, z);
    if (r) begin
      m_phase = PH_IDLE; m_side = 0; m_moves = 0; m_win = 2'b00;
      m_reload = 1'b0; m_boot = 1'b1;
      return;
    end
    m_reload = m_boot;
    m_boot   = 1'b0;
    case (m_phase)
      PH_IDLE: if (s) begin m_phase = PH_RUN; m_side = P_FIRST; end
      PH_RUN: begin
        if (s) begin
          m_phase = PH_IDLE; m_moves = 0; m_reload = 1'b1;
        end else if (z[m_side]) begin
          m_phase = PH_OVER; m_win[1 - m_side] = 1'b1;
        end else if (p) begin
          m_phase = PH_PAUSE;
        end else if (t[m_side]) begin
          if (m_side != P_FIRST && m_moves < P_MAX) m_moves++;
          m_side = 1 - m_side;
        end
      end
      PH_PAUSE: begin
        if (s) begin
          m_phase = PH_IDLE; m_moves = 0; m_reload = 1'b1;
        end else if (p) begin
          m_phase = PH_RUN;
        end
      end
      default: if (s) begin
        m_phase = PH_IDLE; m_moves = 0; m_win = 2'b00; m_reload = 1'b1;
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    logic [2:0] e_state;
    logic [1:0] e_stop;
    logic [7:0] e_moves;
    case (m_phase)
      PH_IDLE:  e_state = 3'd0;
      PH_RUN:   e_state = 3'(1 + m_side);
      PH_PAUSE: e_state = 3'd3;
      default:  e_state = 3'd4;
    endcase
    e_stop  = (m_phase == PH_RUN) ? (2'b11 & ~(2'b01 << m_side)) : 2'b11;
    e_moves = {4'(m_moves / 10), 4'(m_moves % 10)};
    checks++;
    assert (o_state === e_state) else begin
      errors++; $error("FAIL %s state got %0d expected %0d", tag, o_state, e_state);
    end
    checks++;
    assert (o_stop === e_stop) else begin
      errors++; $error("FAIL %s stop got %b expected %b", tag, o_stop, e_stop);
    end
    checks++;
    assert (o_win === m_win) else begin
      errors++; $error("FAIL %s win got %b expected %b", tag, o_win, m_win);
    end
    checks++;
    assert (o_reload === m_reload) else begin
      errors++; $error("FAIL %s reload got %b expected %b", tag, o_reload, m_reload);
    end
    checks++;
    assert (o_moves === e_moves) else begin
      errors++; $error("FAIL %s moves got %h expected %h", tag, o_moves, e_moves);
    end
  endtask

  task automatic cyc(input string tag, input logic r, s, p, input logic [1:0] t, z);
    rst = r; start = s; pause = p; turn = t; zero = z;
    @(posedge clk);
    #1;
    model(r, s, p, t, z);
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; turn = 2'b00; zero = 2'b00;
    m_phase = PH_IDLE; m_side = 0; m_moves = 0; m_win = 2'b00; m_reload = 1'b0; m_boot = 1'b1;
    @(negedge clk);
    cyc("reset", 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    cyc("reset2", 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    cyc("boot_reload", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    cyc("idle_quiet", 1'b0, 1'b0, 1'b1, 2'b11, 2'b11);
    cyc("start", 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    cyc("turn_a", 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
    cyc("turn_b", 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);
    cyc("turn_b_ignored", 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);
    cyc("zero_b_ignored", 1'b0, 1'b0, 1'b0, 2'b00, 2'b10);
    cyc("turn_a2", 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
    cyc("pause_b", 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
    cyc("pause_turn", 1'b0, 1'b0, 1'b0, 2'b11, 2'b00);
    cyc("pause_zero", 1'b0, 1'b0, 1'b0, 2'b00, 2'b11);
    cyc("resume_b", 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
    cyc("turn_b2", 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);
    cyc("zero_turn_a", 1'b0, 1'b0, 1'b0, 2'b01, 2'b01);
    cyc("over_hold", 1'b0, 1'b0, 1'b1, 2'b11, 2'b11);
    cyc("over_start", 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    cyc("idle_after", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    cyc("start2", 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    cyc("both_zero_a", 1'b0, 1'b0, 1'b0, 2'b00, 2'b11);
    cyc("over_start2", 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    cyc("start3", 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    for (int i = 0; i < 101; i++) begin
      cyc("sat_a", 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
      cyc("sat_b", 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);
    end
    cyc("start_pause_prio", 1'b0, 1'b1, 1'b1, 2'b01, 2'b01);
    cyc("start4", 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    cyc("run_turn", 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
    cyc("zero_b_win_a", 1'b0, 1'b0, 1'b1, 2'b10, 2'b10);
    cyc("over_start3", 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    cyc("start5", 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    cyc("run_turn2", 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
    cyc("mid_reset", 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    cyc("after_reset", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    for (int i = 0; i < 3000; i++) begin
      cyc("rand",
          ($urandom_range(0, 599) == 0),
          ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 11) == 0),
          2'($urandom_range(0, 3)),
          {($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0)});
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
